// File: rtl/data_mem_ctrl.sv
// Data memory controller: word RAM with byte/half/word access, byte-lane writes,
// sign/zero-extended loads, configurable wait states and error reporting.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned WAIT_CYC   = 0,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    // Not reset; starts zeroed.
    logic [31:0]         mem [Words] = '{default: '0};

    logic                do_access;
    logic                err;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]          lane;
    logic [4:0]          sh;
    logic [3:0]          be;
    logic [31:0]         wr_data;
    logic [31:0]         rd_word;
    logic [31:0]         rd_shift;
    logic [31:0]         ld_data;

    assign req_ready = (state_q == StIdle);
    assign do_access = (state_q == StBusy) && (cnt_q == 4'd0);
    assign idx       = addr_q[DEPTH_LOG2+1:2];
    assign lane      = addr_q[1:0];
    assign sh        = {lane, 3'b000};

    // Decode errors, lane enables and aligned load/store data from the latched request
    always_comb begin
        err = 1'b0;
        if (size_q == 2'b11) err = 1'b1;
        if ((size_q == 2'b01) && addr_q[0]) err = 1'b1;
        if ((size_q == 2'b10) && (lane != 2'b00)) err = 1'b1;
        if ((addr_q >> (DEPTH_LOG2 + 2)) != '0) err = 1'b1;

        // Misaligned halves/words are already flagged, so a plain shift lines up the lanes.
        wr_data = wdata_q << sh;
        case (size_q)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        rd_word  = mem[idx];
        rd_shift = rd_word >> sh;
        case (size_q)
            2'b00:   ld_data = signed_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                        : {24'h0, rd_shift[7:0]};
            2'b01:   ld_data = signed_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                        : {16'h0, rd_shift[15:0]};
            2'b10:   ld_data = rd_word;
            default: ld_data = 32'h0;
        endcase
    end

    // Commit the store on the access edge unless the request is in error
    always_ff @(posedge clk) begin
        if (do_access && we_q && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Request FSM: latch in IDLE, count wait states in BUSY, pulse response in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    rsp_valid <= 1'b0;
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        cnt_q    <= 4'(WAIT_CYC);
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || we_q) ? 32'h0 : ld_data;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    rsp_valid <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: one controller with no wait states, one with three.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld0, vld3;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rdy0, rdy3;
    logic        rv0, rv3;
    logic [31:0] rd0, rd3;
    logic        er0, er3;

    int n_cmp = 0;
    int n_err = 0;
    int tsel  = 0;

    logic        cur_rdy, cur_rv, cur_er;
    logic [31:0] cur_rd;
    assign cur_rdy = (tsel == 0) ? rdy0 : rdy3;
    assign cur_rv  = (tsel == 0) ? rv0  : rv3;
    assign cur_rd  = (tsel == 0) ? rd0  : rd3;
    assign cur_er  = (tsel == 0) ? er0  : er3;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_LOG2(5), .WAIT_CYC(0), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld0), .req_ready(rdy0), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
    );

    data_mem_ctrl #(.DEPTH_LOG2(5), .WAIT_CYC(3), .ADDR_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld3), .req_ready(rdy3), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction. With hold=1, req_valid stays high and the other request
    // fields are scrambled until the block is idle again.
    task automatic xfer(input string tag, input int sel, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output logic [31:0] rdata, output logic err,
                        output int lat, output int lows);
        bit seen;
        int cyc;
        tsel = sel;
        @(negedge clk);
        check({tag, "_ready"}, 32'(cur_rdy), 32'd1);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        if (sel == 0) vld0 = 1'b1; else vld3 = 1'b1;
        @(posedge clk); #1;
        if (hold) begin
            req_we = 1'b1; req_size = 2'b10; req_addr = 32'h8; req_wdata = 32'hFFFF_FFFF;
        end else begin
            vld0 = 1'b0; vld3 = 1'b0;
        end
        seen = 0; cyc = 0; lat = 0; lows = 0; rdata = '0; err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cur_rdy) break;
            lows++;
            @(posedge clk); #1;
            cyc++;
            if (cur_rv && !seen) begin
                seen = 1; lat = cyc; rdata = cur_rd; err = cur_er;
            end
        end
        vld0 = 1'b0; vld3 = 1'b0;
        check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, lows;

    initial begin
        rst_n = 1'b0; vld0 = 1'b0; vld3 = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready0", 32'(rdy0), 32'd1);
        check("rst_rv0", 32'(rv0), 32'd0);
        check("rst_rd0", rd0, 32'h0);
        check("rst_er0", 32'(er0), 32'd0);
        check("rst_ready3", 32'(rdy3), 32'd1);
        @(negedge clk) rst_n = 1'b1;

        // Known-zero baseline for words that later depend on untouched bytes
        xfer("init0", 0, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0, 0, rd, er, lat, lows);
        xfer("init8", 0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0, 0, rd, er, lat, lows);

        xfer("sw4", 0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h1234_5678, 0, rd, er, lat, lows);
        check("sw4_lat", 32'(lat), 32'd1);
        check("sw4_lows", 32'(lows), 32'd2);
        check("sw4_err", 32'(er), 32'd0);
        check("sw4_rd", rd, 32'h0);
        xfer("lw4", 0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 0, rd, er, lat, lows);
        check("lw4_rd", rd, 32'h1234_5678);
        check("lw4_err", 32'(er), 32'd0);
        check("lw4_lat", 32'(lat), 32'd1);
        check("lw4_lows", 32'(lows), 32'd2);

        xfer("sb6", 0, 1'b1, 2'b00, 1'b0, 32'h06, 32'h0000_00AB, 0, rd, er, lat, lows);
        xfer("lw4b", 0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 0, rd, er, lat, lows);
        check("lw4b_rd", rd, 32'h12AB_5678);
        xfer("lbs6", 0, 1'b0, 2'b00, 1'b1, 32'h06, 32'h0, 0, rd, er, lat, lows);
        check("lbs6_rd", rd, 32'hFFFF_FFAB);
        xfer("lbu6", 0, 1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 0, rd, er, lat, lows);
        check("lbu6_rd", rd, 32'h0000_00AB);
        xfer("lhs6", 0, 1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 0, rd, er, lat, lows);
        check("lhs6_rd", rd, 32'h0000_12AB);
        xfer("lbu7", 0, 1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 0, rd, er, lat, lows);
        check("lbu7_rd", rd, 32'h0000_0012);

        xfer("sh8", 0, 1'b1, 2'b01, 1'b0, 32'h08, 32'h5555_8001, 0, rd, er, lat, lows);
        xfer("lw8", 0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, rd, er, lat, lows);
        check("lw8_rd", rd, 32'h0000_8001);
        xfer("lhs8", 0, 1'b0, 2'b01, 1'b1, 32'h08, 32'h0, 0, rd, er, lat, lows);
        check("lhs8_rd", rd, 32'hFFFF_8001);
        xfer("lhu8", 0, 1'b0, 2'b01, 1'b0, 32'h08, 32'h0, 0, rd, er, lat, lows);
        check("lhu8_rd", rd, 32'h0000_8001);

        // Error cases: each must flag, return zero and leave memory alone
        xfer("e_lw5", 0, 1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 0, rd, er, lat, lows);
        check("e_lw5_err", 32'(er), 32'd1);
        check("e_lw5_rd", rd, 32'h0);
        xfer("e_sh9", 0, 1'b1, 2'b01, 1'b0, 32'h09, 32'hFFFF_FFFF, 0, rd, er, lat, lows);
        check("e_sh9_err", 32'(er), 32'd1);
        check("e_sh9_rd", rd, 32'h0);
        xfer("e_sz3", 0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 0, rd, er, lat, lows);
        check("e_sz3_err", 32'(er), 32'd1);
        check("e_sz3_rd", rd, 32'h0);
        xfer("e_sw80", 0, 1'b1, 2'b10, 1'b0, 32'h80, 32'hFFFF_FFFF, 0, rd, er, lat, lows);
        check("e_sw80_err", 32'(er), 32'd1);
        xfer("e_lw80", 0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 0, rd, er, lat, lows);
        check("e_lw80_err", 32'(er), 32'd1);
        check("e_lw80_rd", rd, 32'h0);
        xfer("post4", 0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 0, rd, er, lat, lows);
        check("post4_rd", rd, 32'h12AB_5678);
        check("post4_err", 32'(er), 32'd0);
        xfer("post8", 0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, rd, er, lat, lows);
        check("post8_rd", rd, 32'h0000_8001);
        xfer("post0", 0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 0, rd, er, lat, lows);
        check("post0_rd", rd, 32'h0);

        // Three wait states
        xfer("w_init8", 3, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0, 0, rd, er, lat, lows);
        xfer("w_initc", 3, 1'b1, 2'b10, 1'b0, 32'h0C, 32'h0, 0, rd, er, lat, lows);
        xfer("w_sw4", 3, 1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFE_F00D, 0, rd, er, lat, lows);
        check("w_sw4_lat", 32'(lat), 32'd4);
        xfer("w_lw4", 3, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1, rd, er, lat, lows);
        check("w_lw4_lat", 32'(lat), 32'd4);
        check("w_lw4_lows", 32'(lows), 32'd5);
        check("w_lw4_rd", rd, 32'hCAFE_F00D);
        xfer("w_lw8", 3, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, rd, er, lat, lows);
        check("w_lw8_rd", rd, 32'h0);

        // Reset two cycles into a waited store: nothing may commit
        xfer("w_lw4c", 3, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 0, rd, er, lat, lows);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0C;
        req_wdata = 32'hDEAD_BEEF; vld3 = 1'b1;
        @(posedge clk); #1;
        vld3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(rdy3), 32'd1);
        check("abort_rv", 32'(rv3), 32'd0);
        check("abort_rd", rd3, 32'h0);
        check("abort_er", 32'(er3), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        xfer("abort_lwc", 3, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 0, rd, er, lat, lows);
        check("abort_lwc_rd", rd, 32'h0);
        check("abort_lwc_err", 32'(er), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised data memory for the single-cycle/multicycle CPU data path.
- Generalises the fixed 32x32 word RAM: configurable depth, configurable wait states, byte/half/word accesses with byte-lane writes and sign/zero-extended loads, and misalignment/out-of-range error reporting.
- Sits between the CPU memory stage and the data store.
- Uses a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- DEPTH_LOG2, 5: number of 32-bit words = 2^DEPTH_LOG2 (5 gives 32 words).
- WAIT_CYC, 0: extra wait-state cycles inserted before each access completes (0..15).
- ADDR_W, 32: width of the byte address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; equals (state==IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  one-cycle pulse: access completed.
- rsp_rdata  output  32  load result, extended; 0 for stores and on error.
- rsp_err  output  1  valid with rsp_valid: misaligned, illegal size or out of range.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all latched request fields cleared.
  - Memory array is not reset; it is zero-initialised at time 0.
  - Reset mid-operation aborts the access. No write commits unless its commit edge has already occurred.
- Clock and reset naming: single clock clk; reset rst_n is asynchronous and active-low.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. If req_valid=1 at a rising edge, latch we/size/signed/addr/wdata, load counter=WAIT_CYC, go to BUSY. Otherwise stay in IDLE.
  - BUSY: req_ready=0. If counter!=0, decrement. If counter==0, perform the access on this edge: commit the write, capture the read, and compute the error. Then set rsp_valid=1 and go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle; req_ready=0. Next edge: rsp_valid=0, go to IDLE. rsp_rdata and rsp_err hold until the next response.
- Latency: accept edge to rsp_valid high = WAIT_CYC+1 cycles. Minimum request spacing = WAIT_CYC+3 cycles.
- No response backpressure. req_* inputs are ignored outside IDLE.
- Word index = addr[DEPTH_LOG2+1:2]. Lane = addr[1:0].
- Error conditions (error cancels the write; rsp_rdata=0):
  - size=11
  - size=01 and addr[0]=1
  - size=10 and addr[1:0]!=0
  - any addr bit at or above DEPTH_LOG2+2 set
- Stores: only the addressed lanes change; other bytes are preserved.
  - byte: wdata[7:0] written to lane addr[1:0].
  - half: wdata[15:0] written to lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes written.
- Loads: the selected byte/half is right-justified.
  - req_signed=1: sign-extend from bit 7/15.
  - req_signed=0: zero-extend.
  - word: returned unchanged.
- Little-endian: lane 0 = bits [7:0].
- Read-after-write: a load issued after a store's rsp_valid returns the new data.

Test Plan:
- Reset, then word store addr 0x04 data 0x12345678, then word load 0x04 (WAIT_CYC=0) -> rsp_valid 1 cycle after each accept; load rsp_rdata=0x12345678, rsp_err=0; req_ready low for exactly 2 cycles per request.
- From 0x12345678 at 0x04: byte store 0xAB to 0x06 -> word reads 0x12AB5678. Signed byte load 0x06 -> 0xFFFFFFAB. Unsigned -> 0x000000AB. Signed half load 0x06 -> 0x000012AB.
- Half store 0x8001 to 0x08 -> word at 0x08 reads 0x00008001. Signed half load 0x08 -> 0xFFFF8001. Unsigned half load 0x08 -> 0x00008001.
- Errors: word load 0x05, half store 0x09, size=11 at 0x00, word store 0x80 (DEPTH_LOG2=5) -> each gives rsp_err=1, rsp_rdata=0; memory at 0x04/0x08 unchanged.
- WAIT_CYC=3: word load 0x04 -> rsp_valid exactly 4 cycles after the accept edge. req_valid held high through BUSY -> no second accept until IDLE.
- WAIT_CYC=3: store 0xDEADBEEF to 0x0C, rst_n pulsed low 2 cycles after accept -> outputs return to 0 and req_ready=1 immediately; subsequent load 0x0C returns 0x00000000.
